// File: rtl/sumador_pkg.sv
// Shared definitions for the bit-serial adder: FSM state type and default width.
package sumador_pkg;

  localparam int SUMADOR_N = 4;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

endpackage

// File: rtl/sumador_1.sv
// 1-bit full-adder cell; purely combinational.
module sumador_1 (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  assign s    = a ^ b ^ cin;
  assign cout = (a & b) | (cin & (a ^ b));

endmodule

// File: rtl/sumador_serial.sv
// Bit-serial N-bit adder: operands are shifted LSB-first through one full-adder
// cell, one bit per clock, with the running carry held in a flop.
// Optional feature: define SUMADOR_OVERFLOW_EN to add the signed overflow output.
module sumador_serial
  import sumador_pkg::*;
#(
  parameter int N = SUMADOR_N
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] A_num,
  input  logic [N-1:0] B_num,
  input  logic         carry_in,
  output logic         ready,
  output logic         done,
  output logic [N-1:0] result,
  output logic         carry_out
`ifdef SUMADOR_OVERFLOW_EN
  ,
  output logic         overflow
`endif
);

  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  state_t           state_q;
  state_t           state_d;
  logic [N-1:0]     a_sr;
  logic [N-1:0]     b_sr;
  logic [N-1:0]     s_sr;
  logic             c_q;
  logic [CNT_W-1:0] cnt_q;
  logic             sum_bit;
  logic             cell_cout;
  logic             last_bit;

  sumador_1 u_cell (
    .a    (a_sr[0]),
    .b    (b_sr[0]),
    .cin  (c_q),
    .s    (sum_bit),
    .cout (cell_cout)
  );

  assign last_bit = (cnt_q == LAST);

  // Handshake outputs decode straight from the state register.
  assign ready = (state_q == IDLE);
  assign done  = (state_q == DONE);

  // State register; reset overrides any start in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  // Next-state logic: IDLE -> SHIFT on start, SHIFT for N bits, one DONE cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = DONE;
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Operand capture, bit-serial shifting and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_sr      <= '0;
      b_sr      <= '0;
      s_sr      <= '0;
      c_q       <= 1'b0;
      cnt_q     <= '0;
      result    <= '0;
      carry_out <= 1'b0;
`ifdef SUMADOR_OVERFLOW_EN
      overflow  <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (start) begin
            a_sr  <= A_num;
            b_sr  <= B_num;
            c_q   <= carry_in;
            cnt_q <= '0;
            s_sr  <= '0;
          end
        end
        SHIFT: begin
          a_sr <= a_sr >> 1;
          b_sr <= b_sr >> 1;
          s_sr <= {sum_bit, s_sr[N-1:1]};
          c_q  <= cell_cout;
          if (last_bit) begin
            // Counter parks at zero rather than stepping past N-1.
            cnt_q     <= '0;
            result    <= {sum_bit, s_sr[N-1:1]};
            carry_out <= cell_cout;
`ifdef SUMADOR_OVERFLOW_EN
            // Carry into the MSB differs from carry out of it.
            overflow  <= c_q ^ cell_cout;
`endif
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sumador_serial.sv
// Self-checking bench for sumador_serial (N=4), directed plus random operations
// compared against an arithmetic reference model.
module tb_sumador_serial;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [N-1:0] A_num;
  logic [N-1:0] B_num;
  logic         carry_in;
  logic         ready;
  logic         done;
  logic [N-1:0] result;
  logic         carry_out;
`ifdef SUMADOR_OVERFLOW_EN
  logic         overflow;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  sumador_serial #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .A_num     (A_num),
    .B_num     (B_num),
    .carry_in  (carry_in),
    .ready     (ready),
    .done      (done),
    .result    (result),
    .carry_out (carry_out)
`ifdef SUMADOR_OVERFLOW_EN
    ,
    .overflow  (overflow)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain integer addition of the captured operands.
  function automatic int model_sum(input int a, input int b, input int cin);
    return a + b + cin;
  endfunction

  function automatic int model_ovf(input int a, input int b, input int cin);
    int sa, sb, s;
    sa = (a >= (1 << (N - 1))) ? a - (1 << N) : a;
    sb = (b >= (1 << (N - 1))) ? b - (1 << N) : b;
    s  = sa + sb + cin;
    return (s > (1 << (N - 1)) - 1 || s < -(1 << (N - 1))) ? 1 : 0;
  endfunction

  // Waits for done, counting negedges; returns cycles elapsed (or -1 on timeout).
  task automatic wait_done(output int cycles);
    cycles = -1;
    for (int i = 1; i <= 20; i++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        cycles = i;
        break;
      end
    end
  endtask

  // One complete operation: called at a negedge with ready high.
  task automatic run_op(input string tag, input int a, input int b, input int cin);
    int cyc;
    int s;
    check({tag, "_ready_before"}, ready, 1);
    A_num = a[N-1:0]; B_num = b[N-1:0]; carry_in = cin[0];
    start = 1'b1;
    @(negedge clk);                   // accept edge passed
    start = 1'b0;
    check({tag, "_ready_busy"}, ready, 0);
    wait_done(cyc);
    check({tag, "_latency"}, cyc, N);
    s = model_sum(a, b, cin);
    check({tag, "_result"}, result, s % (1 << N));
    check({tag, "_carry"}, carry_out, (s >> N) & 1);
`ifdef SUMADOR_OVERFLOW_EN
    check({tag, "_ovf"}, overflow, model_ovf(a, b, cin));
`endif
    @(negedge clk);
    check({tag, "_done_fall"}, done, 0);
    check({tag, "_ready_back"}, ready, 1);
  endtask

  initial begin
    int cyc;
    int dones;
    int a, b, c;
    rst = 1'b1; start = 1'b0; A_num = '0; B_num = '0; carry_in = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("idle_ready", ready, 1);
      check("idle_done", done, 0);
      check("idle_result", result, 0);
      check("idle_carry", carry_out, 0);
    end

    run_op("op3p5", 3, 5, 0);

    // Back-to-back with start held high across the first operation.
    A_num = 4'd15; B_num = 4'd1; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    A_num = 4'd7; B_num = 7; carry_in = 1'b1;
    wait_done(cyc);
    check("b2b1_latency", cyc, N);
    check("b2b1_result", result, 0);
    check("b2b1_carry", carry_out, 1);
    @(negedge clk);
    check("b2b_ready", ready, 1);
    @(negedge clk);                   // second accepted at first ready
    start = 1'b0;
    check("b2b2_busy", ready, 0);
    wait_done(cyc);
    check("b2b2_latency", cyc, N);
    check("b2b2_result", result, 15);
    check("b2b2_carry", carry_out, 0);
    @(negedge clk);

    // Busy rejection: second start during SHIFT must be ignored.
    A_num = 4'd2; B_num = 4'd2; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    A_num = 4'd9; B_num = 4'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      if (done === 1'b1) dones++;
      @(negedge clk);
    end
    check("busy_dones", dones, 1);
    check("busy_result", result, 4);
    check("busy_ready", ready, 1);

    // Reset in the 2nd SHIFT cycle discards the operation.
    A_num = 4'd6; B_num = 4'd6; carry_in = 1'b0; start = 1'b1;
    @(negedge clk);                   // accept edge k
    start = 1'b0;
    @(negedge clk);                   // after k+1
    rst = 1'b1;
    @(negedge clk);                   // reset applied at k+2
    check("rst_done", done, 0);
    check("rst_ready", ready, 1);
    check("rst_result", result, 0);
    check("rst_carry", carry_out, 0);
    // start together with rst is ignored
    start = 1'b1;
    @(negedge clk);
    rst = 1'b0; start = 1'b0;
    check("rst_start_ignored", ready, 1);
    dones = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (done === 1'b1) dones++;
    end
    check("rst_no_done", dones, 0);
    run_op("after_rst", 1, 1, 0);

`ifdef SUMADOR_OVERFLOW_EN
    run_op("ovf7p1", 7, 1, 0);
    run_op("ovf8p8", 8, 8, 0);
    run_op("ovf3p2", 3, 2, 0);
`endif

    // Random operations.
    for (int i = 0; i < 30; i++) begin
      a = int'($urandom_range(0, (1 << N) - 1));
      b = int'($urandom_range(0, (1 << N) - 1));
      c = int'($urandom_range(0, 1));
      run_op("rand", a, b, c);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
